// File: rtl/alu_result_select_pipe_pkg.sv
// Shared CPU package for the ALU result select pipeline.
//  - state_t    : skid buffer occupancy states (EMPTY / ONE / FULL)
//  - RES_*      : index of each ALU function unit result on the packed result bus
package alu_result_select_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int RES_AND = 0;
  localparam int RES_OR  = 1;
  localparam int RES_ADD = 2;
  localparam int RES_SLT = 3;
  localparam int RES_MUL = 4;
  localparam int RES_XOR = 5;
  localparam int RES_SLL = 6;

  localparam int NUM_RES = 7;

endpackage

// File: rtl/alu_result_select_pipe_buf.sv
// result_skid_buffer: 2-entry FIFO-ordered valid/ready buffer for a PW-bit payload.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1 on that side. Upstream: push = in_valid & in_ready. Downstream:
// pop = out_valid & out_ready. valid must not depend on ready on either side,
// and in_ready / out_valid are both driven straight from registers.
//
// Ports:
//  clk        in   rising-edge clock
//  rst_n      in   synchronous active-low reset
//  flush      in   discard all entries; an accept in the same cycle is dropped
//  in_data    in   PW-bit payload offered by the producer
//  in_valid   in   producer offers in_data
//  in_ready   out  buffer can take a payload (0 only in FULL)
//  out_data   out  head payload (main register)
//  out_valid  out  out_data holds a valid entry
//  out_ready  in   consumer takes the head entry
//  state      out  current occupancy state, for debug and checkers
module result_skid_buffer
  import alu_result_select_pipe_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output state_t        state
);

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] main_d;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] skid_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          push;
  logic          pop;

  // A flushed accept still completes the handshake upstream but is discarded.
  assign push = in_valid & in_ready_q & ~flush;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Data registers may still load; they are stale once state is EMPTY.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign state     = state_q;

endmodule

// File: rtl/alu_result_select_pipe.sv
// alu_result_select_pipe: selects one of NUM_IN ALU results by sel and
// registers it behind a 2-entry valid/ready skid buffer. Out-of-range selects
// produce DEFAULT_VAL with out_illegal set and are counted in illegal_cnt.
//
// Ports:
//  clk          in   rising-edge clock
//  rst_n        in   synchronous active-low reset
//  in_bus       in   packed results, input k at [k*WIDTH +: WIDTH]
//  sel          in   result select, sampled with in_valid
//  in_valid     in   producer has a result to transfer
//  in_ready     out  block can accept a transfer
//  flush        in   discard all buffered entries
//  out_data     out  selected result
//  out_sel      out  sel that produced out_data
//  out_illegal  out  sel was >= NUM_IN for this entry
//  out_valid    out  out_* hold a valid entry
//  out_ready    in   consumer accepts the entry
//  illegal_cnt  out  saturating count of accepted illegal selects
module alu_result_select_pipe
  import alu_result_select_pipe_pkg::*;
#(
  parameter int               WIDTH       = 24,
  parameter int               NUM_IN      = NUM_RES,
  parameter int               SEL_W       = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int               CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_illegal,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        illegal_cnt
);

  localparam int PW = 1 + SEL_W + WIDTH;

  logic [WIDTH-1:0] word;
  logic             illegal;
  logic [PW-1:0]    payload_in;
  logic [PW-1:0]    payload_out;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  state_t           state;

  // One extra bit so NUM_IN == 2**SEL_W compares correctly.
  assign illegal = ({1'b0, sel} >= (SEL_W + 1)'(NUM_IN));

  // Compare-per-input mux keeps every select value driven, including
  // the out-of-range ones, without a variable part-select past the bus.
  always_comb begin
    word = DEFAULT_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign payload_in = {illegal, sel, word};

  result_skid_buffer #(
    .PW (PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (payload_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (payload_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state     (state)
  );

  assign {out_illegal, out_sel, out_data} = payload_out;

  // Flushed accepts are dropped, so they are not counted either.
  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign illegal_cnt = cnt_q;

endmodule
